// File: rtl/key_debounce_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_conditioner
// Brief    : Synchronizes, debounces and edge-detects one active-low pushbutton;
//            keeps a wrapping press count and a sticky pending flag with ack.
//            Optional long-press pulse when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COUNT_W         = 16,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               key_n,
    input  logic               ack,
    output logic               key_n_clean,
    output logic               pressed,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               pending,
    output logic [COUNT_W-1:0] press_count,
    output logic               long_press
);

    localparam int              c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [c_DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                   clean_q, clean_d;
    logic                   pressed_q, pressed_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   release_pulse_q, release_pulse_d;
    logic                   pending_q, pending_d;
    logic [COUNT_W-1:0]     press_count_q, press_count_d;
    logic                   w_s;

    assign w_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], key_n};
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        clean_d         = clean_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            ST_UP: begin
                if (!w_s) begin
                    state_d  = ST_WAIT_DOWN;
                    db_cnt_d = '0;
                end
            end
            ST_WAIT_DOWN: begin
                if (w_s) begin
                    state_d  = ST_UP;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_DB_LAST) begin
                    state_d       = ST_DOWN;
                    db_cnt_d      = '0;
                    clean_d       = 1'b0;
                    press_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + c_DB_W'(1);
                end
            end
            ST_DOWN: begin
                if (w_s) begin
                    state_d  = ST_WAIT_UP;
                    db_cnt_d = '0;
                end
            end
            ST_WAIT_UP: begin
                if (!w_s) begin
                    state_d  = ST_DOWN;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_DB_LAST) begin
                    state_d         = ST_UP;
                    db_cnt_d        = '0;
                    clean_d         = 1'b1;
                    release_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + c_DB_W'(1);
                end
            end
            default: begin
                state_d  = ST_UP;
                db_cnt_d = '0;
            end
        endcase
        pressed_d     = ~clean_d;
        // A press arriving with ack in the same cycle keeps pending set
        pending_d     = press_pulse_d | (pending_q & ~ack);
        press_count_d = press_count_q + COUNT_W'(press_pulse_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q          <= '1;
            state_q         <= ST_UP;
            db_cnt_q        <= '0;
            clean_q         <= 1'b1;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            pending_q       <= 1'b0;
            press_count_q   <= '0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            clean_q         <= clean_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            pending_q       <= pending_d;
            press_count_q   <= press_count_d;
        end
    end

    assign key_n_clean   = clean_q;
    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign pending       = pending_q;
    assign press_count   = press_count_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int                  c_HOLD_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);

    logic [c_HOLD_W-1:0] hold_q, hold_d;
    logic                long_q, long_d;
    logic                w_in_hold;

    // Saturating at the terminal value is what prevents a repeat pulse
    always_comb begin
        w_in_hold = (state_q == ST_DOWN) || (state_q == ST_WAIT_UP);
        hold_d    = '0;
        long_d    = 1'b0;
        if (w_in_hold) begin
            if (hold_q != c_HOLD_LAST) begin
                hold_d = hold_q + c_HOLD_W'(1);
                long_d = (hold_d == c_HOLD_LAST);
            end else begin
                hold_d = hold_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    logic w_unused_long;
    assign w_unused_long = ^LONG_CYCLES;
    assign long_press    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_conditioner
// Brief    : Directed and random stimulus for key_debounce_conditioner, checked
//            against a run-length reference model of the debounce rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int COUNT_W         = 4;
    localparam int LONG_CYCLES     = 20;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               key_n = 1'b1;
    logic               ack = 1'b0;
    logic               key_n_clean;
    logic               pressed;
    logic               press_pulse;
    logic               release_pulse;
    logic               pending;
    logic [COUNT_W-1:0] press_count;
    logic               long_press;

    always #5 clk = ~clk;

    key_debounce_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .COUNT_W         (COUNT_W),
        .LONG_CYCLES     (LONG_CYCLES)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .key_n         (key_n),
        .ack           (ack),
        .key_n_clean   (key_n_clean),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .pending       (pending),
        .press_count   (press_count),
        .long_press    (long_press)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a level change is accepted once DEBOUNCE_CYCLES+1
    // consecutive synchronized samples disagree with the accepted level.
    bit m_sync [SYNC_STAGES];
    bit m_clean, m_pp, m_rp, m_pend, m_long;
    int m_run, m_count, m_since;

    int step_no = 0;
    int n_press = 0, n_release = 0, n_long = 0;
    int last_press_step = -1, last_release_step = -1, last_long_step = -1;

    function automatic void model_edge(input bit rst, input bit k, input bit a);
        bit s;
        s = m_sync[SYNC_STAGES-1];
        for (int i = SYNC_STAGES-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = k;
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b1;
            m_clean = 1'b1; m_run = 0; m_pp = 0; m_rp = 0; m_pend = 0;
            m_count = 0; m_since = 0; m_long = 0;
            return;
        end
        m_pp = 0; m_rp = 0; m_long = 0;
        if (!m_clean) begin
            if (m_since < LONG_CYCLES) m_since++;
            if (m_since == LONG_CYCLES-1) m_long = 1;
        end
        if (s != m_clean) m_run++;
        else m_run = 0;
        if (m_run == DEBOUNCE_CYCLES+1) begin
            m_run   = 0;
            m_clean = s;
            if (!s) begin
                m_pp    = 1;
                m_since = 0;
                m_count = (m_count + 1) % (1 << COUNT_W);
            end else begin
                m_rp = 1;
            end
        end
        m_pend = m_pp ? 1'b1 : (a ? 1'b0 : m_pend);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic step(input bit rst, input bit k, input bit a);
        bit exp_long;
        reset = rst; key_n = k; ack = a;
        @(posedge clk);
        model_edge(rst, k, a);
        #1;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        exp_long = m_long;
`else
        exp_long = 1'b0;
`endif
        chk("key_n_clean",   32'(key_n_clean),   32'(m_clean));
        chk("pressed",       32'(pressed),       32'(!m_clean));
        chk("press_pulse",   32'(press_pulse),   32'(m_pp));
        chk("release_pulse", 32'(release_pulse), 32'(m_rp));
        chk("pending",       32'(pending),       32'(m_pend));
        chk("press_count",   32'(press_count),   32'(m_count));
        chk("long_press",    32'(long_press),    32'(exp_long));
        if (press_pulse === 1'b1)   begin n_press++;   last_press_step = step_no;   end
        if (release_pulse === 1'b1) begin n_release++; last_release_step = step_no; end
        if (long_press === 1'b1)    begin n_long++;    last_long_step = step_no;    end
        step_no++;
        @(negedge clk);
    endtask

    task automatic hold(input bit k, input int n);
        for (int i = 0; i < n; i++) step(1'b0, k, 1'b0);
    endtask

    initial begin
        int p0, np, nl, len;
        bit k;
        @(negedge clk);

        // Reset with key released
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        hold(1'b1, 3);

        // Clean press then release
        np = n_press; p0 = step_no;
        hold(1'b0, 10);
        chk("clean_press_count", 32'(n_press - np), 32'd1);
        chk("clean_press_lat",   32'(last_press_step - p0), 32'd6);
        chk("clean_cnt_val",     32'(press_count), 32'd1);
        p0 = step_no;
        hold(1'b1, 10);
        chk("clean_release_lat", 32'(last_release_step - p0), 32'd6);

        // Bounce: 0,1,0,1 for two cycles each, then steady low
        np = n_press;
        hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2);
        p0 = step_no;
        hold(1'b0, 10);
        chk("bounce_press_count", 32'(n_press - np), 32'd1);
        chk("bounce_press_lat",   32'(last_press_step - p0), 32'd6);
        hold(1'b1, 10);

        // Ack on the same edge that accepts the press
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("pend_press_wins", 32'(pending), 32'd1);
        hold(1'b0, 3);
        step(1'b0, 1'b0, 1'b1);
        chk("pend_lone_ack", 32'(pending), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        hold(1'b1, 10);

        // Counter wrap after 17 presses from reset
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        chk("wrap_count", 32'(press_count), 32'd1);

        // Reset during WAIT_DOWN, key still held afterwards
        np = n_press;
        hold(1'b0, 3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_no_pulse", 32'(n_press - np), 32'd0);
        p0 = step_no;
        hold(1'b0, 10);
        chk("rst_held_press", 32'(n_press - np), 32'd1);
        chk("rst_held_lat",   32'(last_press_step - p0), 32'd6);
        hold(1'b1, 10);

        // Long hold
        nl = n_long; np = n_press;
        hold(1'b0, 6 + 40);
        hold(1'b1, 10);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        chk("long_count", 32'(n_long - nl), 32'd1);
        chk("long_lat",   32'(last_long_step - last_press_step), 32'd19);
`else
        chk("long_count", 32'(n_long - nl), 32'd0);
`endif
        chk("long_press_once", 32'(n_press - np), 32'd1);

        // Random key runs with occasional ack and reset
        k = 1'b1;
        for (int r = 0; r < 120; r++) begin
            k   = ~k;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 199) == 0), k, ($urandom_range(0, 7) == 0));
        end
        hold(1'b1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
